// File: rtl/dmem_responder_if.sv
// Request/response bundle between the pipeline's DMEM port and the data memory.
// Vectors use big-endian bit numbering: bit 0 is the most significant bit.
interface dmem_responder_if;
   logic        req_valid;
   logic [0:31] addr_to_mem;
   logic        write_enable_to_mem;
   logic        byte_to_mem;
   logic        half_word_to_mem;
   logic        sign_extend_to_mem;
   logic [0:31] data_to_mem;
   logic [0:31] data_from_mem;
   logic        mem_ready;
   logic        mem_busy;
   logic        misaligned_err;

   // Processor side: issues requests, observes the response.
   modport master (
      output req_valid,
      output addr_to_mem,
      output write_enable_to_mem,
      output byte_to_mem,
      output half_word_to_mem,
      output sign_extend_to_mem,
      output data_to_mem,
      input  data_from_mem,
      input  mem_ready,
      input  mem_busy,
      input  misaligned_err
   );

   // Memory side: accepts requests, produces the response.
   modport slave (
      input  req_valid,
      input  addr_to_mem,
      input  write_enable_to_mem,
      input  byte_to_mem,
      input  half_word_to_mem,
      input  sign_extend_to_mem,
      input  data_to_mem,
      output data_from_mem,
      output mem_ready,
      output mem_busy,
      output misaligned_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, big-endian lane selection,
// read-modify-write for partial stores, sign/zero extension for partial loads,
// and a fixed response latency signalled by a one-cycle mem_ready pulse.
module dmem_responder #(
   parameter int ADDR_BITS = 10,
   parameter int LATENCY   = 2
) (
   input logic             clock,
   input logic             reset,
   dmem_responder_if.slave bus
);

   localparam int         DEPTH      = 1 << ADDR_BITS;
   localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  count_q, count_d;
   logic [0:31] addr_q, addr_d;
   logic        we_q, we_d;
   logic        byte_q, byte_d;
   logic        half_q, half_d;
   logic        sign_q, sign_d;
   logic [0:31] wdata_q, wdata_d;
   logic [0:31] rdata_q, rdata_d;
   logic        mis_q, mis_d;

   logic [0:31] mem [DEPTH];

   logic                 commit;
   logic                 mem_we;
   logic                 is_byte;
   logic                 is_half;
   logic                 is_word;
   logic                 misaligned;
   logic [ADDR_BITS-1:0] word_idx;
   logic [1:0]           byte_off;
   logic [4:0]           byte_base;
   logic [4:0]           half_base;
   logic [0:31]          old_word;
   logic [0:31]          merged_word;
   logic [0:31]          load_word;
   logic [0:7]           ext_byte;
   logic [0:15]          ext_half;
   logic                 unused_addr_hi;

   // Address bits above the word index are deliberately ignored so the array aliases.
   assign unused_addr_hi = ^addr_q[0:29-ADDR_BITS];

   // Decode access size, lane position, word index and misalignment from the latched request.
   always_comb begin
      is_byte    = byte_q;
      is_half    = !byte_q && half_q;
      is_word    = !byte_q && !half_q;
      byte_off   = addr_q[30:31];
      byte_base  = {byte_off, 3'b000};
      half_base  = {addr_q[30], 4'b0000};
      word_idx   = addr_q[30-ADDR_BITS:29];
      misaligned = (is_half && addr_q[31]) || (is_word && (byte_off != 2'b00));
   end

   // Read the addressed word and overlay only the selected store lanes on it.
   always_comb begin
      old_word    = mem[word_idx];
      merged_word = old_word;
      if (is_byte) begin
         merged_word[byte_base +: 8] = wdata_q[24:31];
      end else if (is_half) begin
         merged_word[half_base +: 16] = wdata_q[16:31];
      end else begin
         merged_word = wdata_q;
      end
   end

   // Extract the addressed lane, right-justify it and fill the upper bits.
   always_comb begin
      ext_byte  = old_word[byte_base +: 8];
      ext_half  = old_word[half_base +: 16];
      load_word = old_word;
      if (misaligned) begin
         load_word = '0;
      end else if (is_byte) begin
         load_word = {{24{sign_q & ext_byte[0]}}, ext_byte};
      end else if (is_half) begin
         load_word = {{16{sign_q & ext_half[0]}}, ext_half};
      end
   end

   // Sequencing: accept in IDLE/RESP, count down in WAIT, commit and respond.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      addr_d  = addr_q;
      we_d    = we_q;
      byte_d  = byte_q;
      half_d  = half_q;
      sign_d  = sign_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      mis_d   = mis_q;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE, ST_RESP: begin
            if (bus.req_valid) begin
               addr_d  = bus.addr_to_mem;
               we_d    = bus.write_enable_to_mem;
               byte_d  = bus.byte_to_mem;
               half_d  = bus.half_word_to_mem;
               sign_d  = bus.sign_extend_to_mem;
               wdata_d = bus.data_to_mem;
               count_d = COUNT_LOAD;
               state_d = ST_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (count_q != 4'd0) begin
               count_d = count_q - 4'd1;
            end else begin
               commit  = 1'b1;
               rdata_d = we_q ? '0 : load_word;
               mis_d   = misaligned;
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign mem_we = commit && we_q && !misaligned;

   // Backing array is never reset; a store lands only on its commit edge.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[word_idx] <= merged_word;
      end
   end

   // Control and response registers; reset drops any in-flight transaction.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         count_q <= 4'd0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         byte_q  <= 1'b0;
         half_q  <= 1'b0;
         sign_q  <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         byte_q  <= byte_d;
         half_q  <= half_d;
         sign_q  <= sign_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         mis_q   <= mis_d;
      end
   end

   assign bus.data_from_mem  = rdata_q;
   assign bus.mem_ready      = (state_q == ST_RESP);
   assign bus.mem_busy       = (state_q == ST_WAIT);
   assign bus.misaligned_err = (state_q == ST_RESP) && mis_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances with LATENCY 2, 1 and 3, each with
// its own request signals, checked against a word-array reference model.
module tb_dmem_responder;

   localparam int NDUT = 3;
   localparam int LAT [NDUT] = '{2, 1, 3};

   localparam logic        B2B_WE   [3] = '{1'b1, 1'b0, 1'b0};
   localparam logic        B2B_BYTE [3] = '{1'b0, 1'b1, 1'b0};
   localparam logic        B2B_HALF [3] = '{1'b0, 1'b0, 1'b1};
   localparam logic        B2B_SIGN [3] = '{1'b0, 1'b1, 1'b0};
   localparam logic [31:0] B2B_ADDR [3] = '{32'h200, 32'h201, 32'h202};
   localparam logic [31:0] B2B_DATA [3] = '{32'h5A5A_1234, 32'h0, 32'h0};

   logic clock = 1'b0;

   // Free-running 10-time-unit clock.
   always #5 clock = ~clock;

   logic        rst_n_s     [NDUT];
   logic        req_valid_s [NDUT];
   logic [31:0] addr_s      [NDUT];
   logic        we_s        [NDUT];
   logic        byte_s      [NDUT];
   logic        half_s      [NDUT];
   logic        sign_s      [NDUT];
   logic [31:0] data_s      [NDUT];
   logic [31:0] rdata_o     [NDUT];
   logic        ready_o     [NDUT];
   logic        busy_o      [NDUT];
   logic        mis_o       [NDUT];

   logic [31:0] model [NDUT][1024];
   logic [31:0] b2b_exp [3];
   int vectors     = 0;
   int miscompares = 0;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      dmem_responder_if bus ();
      assign bus.req_valid           = req_valid_s[g];
      assign bus.addr_to_mem         = addr_s[g];
      assign bus.write_enable_to_mem = we_s[g];
      assign bus.byte_to_mem         = byte_s[g];
      assign bus.half_word_to_mem    = half_s[g];
      assign bus.sign_extend_to_mem  = sign_s[g];
      assign bus.data_to_mem         = data_s[g];
      assign rdata_o[g]              = bus.data_from_mem;
      assign ready_o[g]              = bus.mem_ready;
      assign busy_o[g]               = bus.mem_busy;
      assign mis_o[g]                = bus.misaligned_err;

      dmem_responder #(.ADDR_BITS(10), .LATENCY(LAT[g])) u_dut (
         .clock (clock),
         .reset (rst_n_s[g]),
         .bus   (bus)
      );
   end

   function automatic logic is_misaligned(input logic [31:0] a, input logic byt, input logic half);
      if (byt) return 1'b0;
      if (half) return a[0];
      return a[1:0] != 2'b00;
   endfunction

   // Expected load result (0 for stores); applies stores to the model in accept order.
   function automatic logic [31:0] predict(input int d, input logic we, input logic byt,
                                           input logic half, input logic sgn,
                                           input logic [31:0] a, input logic [31:0] dat);
      int unsigned idx;
      int unsigned width;
      int unsigned shift;
      logic [31:0] mask;
      logic [31:0] word;
      logic [31:0] field;
      if (is_misaligned(a, byt, half)) return 32'h0;
      idx   = int'(a[11:2]);
      width = byt ? 8 : (half ? 16 : 32);
      shift = byt ? 8 * (3 - int'(a[1:0])) : (half ? (a[1] ? 0 : 16) : 0);
      mask  = (width == 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      word  = model[d][idx];
      if (we) begin
         model[d][idx] = (word & ~(mask << shift)) | ((dat & mask) << shift);
         return 32'h0;
      end
      field = (word >> shift) & mask;
      if (sgn && field[width-1]) field = field | ~mask;
      return field;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic drive(input int d, input logic we, input logic byt, input logic half,
                        input logic sgn, input logic [31:0] a, input logic [31:0] dat);
      we_s[d]   = we;
      byte_s[d] = byt;
      half_s[d] = half;
      sign_s[d] = sgn;
      addr_s[d] = a;
      data_s[d] = dat;
   endtask

   // One complete transaction: accept, latency count, response contents, pulse end.
   task automatic applyStimulus(input int d, input logic we, input logic byt, input logic half,
                                input logic sgn, input logic [31:0] a, input logic [31:0] dat,
                                input string tag);
      logic [31:0] exp_data;
      logic        exp_mis;
      int          edges;
      string       t;
      t        = $sformatf("L%0d/%s", LAT[d], tag);
      exp_mis  = is_misaligned(a, byt, half);
      exp_data = predict(d, we, byt, half, sgn, a, dat);
      @(negedge clock);
      drive(d, we, byt, half, sgn, a, dat);
      req_valid_s[d] = 1'b1;
      @(posedge clock);
      @(negedge clock);
      req_valid_s[d] = 1'b0;
      checkOutput({t, "/busy"}, busy_o[d], 32'd1);
      edges = 0;
      while (!ready_o[d] && edges < 20) begin
         @(posedge clock);
         @(negedge clock);
         edges++;
      end
      checkOutput({t, "/latency"}, edges, LAT[d]);
      checkOutput({t, "/data"}, rdata_o[d], exp_data);
      checkOutput({t, "/misaligned"}, mis_o[d], exp_mis);
      checkOutput({t, "/busy_resp"}, busy_o[d], 32'd0);
      @(negedge clock);
      checkOutput({t, "/ready_pulse"}, ready_o[d], 32'd0);
   endtask

   // Directed steps followed by randomized traffic, back-to-back and reset scenarios.
   initial begin
      int          rd;
      logic        rwe, rbyte, rhalf, rsign;
      logic [31:0] raddr;

      for (int d = 0; d < NDUT; d++) begin
         rst_n_s[d]     = 1'b1;
         req_valid_s[d] = 1'b0;
         drive(d, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      #2;
      for (int d = 0; d < NDUT; d++) rst_n_s[d] = 1'b0;
      @(negedge clock);
      for (int d = 0; d < NDUT; d++) begin
         checkOutput("reset/ready", ready_o[d], 32'd0);
         checkOutput("reset/busy", busy_o[d], 32'd0);
         checkOutput("reset/misaligned", mis_o[d], 32'd0);
         checkOutput("reset/data", rdata_o[d], 32'd0);
      end
      @(negedge clock);
      for (int d = 0; d < NDUT; d++) rst_n_s[d] = 1'b1;

      for (int d = 0; d < NDUT; d++) begin
         applyStimulus(d, 1, 0, 0, 0, 32'h10,   32'hDEAD_BEEF, "word_store");
         applyStimulus(d, 0, 0, 0, 0, 32'h10,   32'h0,         "word_load");
         applyStimulus(d, 1, 0, 0, 0, 32'h10,   32'h1122_3344, "word_init");
         applyStimulus(d, 1, 1, 0, 0, 32'h13,   32'hFFFF_FF80, "byte_store");
         applyStimulus(d, 0, 0, 0, 0, 32'h10,   32'h0,         "byte_merge");
         applyStimulus(d, 0, 1, 0, 1, 32'h13,   32'h0,         "byte_sx");
         applyStimulus(d, 0, 1, 0, 0, 32'h13,   32'h0,         "byte_zx");
         applyStimulus(d, 0, 1, 0, 1, 32'h10,   32'h0,         "byte0_sx");
         applyStimulus(d, 0, 1, 1, 1, 32'h12,   32'h0,         "byte_over_half");
         applyStimulus(d, 1, 0, 0, 0, 32'h20,   32'h0,         "half_init");
         applyStimulus(d, 1, 0, 1, 0, 32'h22,   32'h1234_A5A5, "half_store");
         applyStimulus(d, 0, 0, 0, 0, 32'h20,   32'h0,         "half_merge");
         applyStimulus(d, 0, 0, 1, 1, 32'h22,   32'h0,         "half_sx");
         applyStimulus(d, 0, 0, 1, 1, 32'h20,   32'h0,         "half_upper");
         applyStimulus(d, 1, 0, 0, 0, 32'h30,   32'h600D_F00D, "mis_init");
         applyStimulus(d, 1, 0, 0, 0, 32'h31,   32'hBADB_AD00, "mis_word_store");
         applyStimulus(d, 0, 0, 0, 0, 32'h30,   32'h0,         "mis_unchanged");
         applyStimulus(d, 0, 0, 1, 1, 32'h33,   32'h0,         "mis_half_load");
         applyStimulus(d, 0, 0, 0, 0, 32'h1010, 32'h0,         "alias_load");
      end

      for (int d = 0; d < NDUT; d++) begin
         for (int w = 0; w < 8; w++) begin
            applyStimulus(d, 1, 0, 0, 0, 32'h100 + 32'(w * 4), $urandom, "rand_init");
         end
      end
      for (int n = 0; n < 40; n++) begin
         rd    = $urandom_range(0, NDUT - 1);
         rwe   = 1'($urandom_range(0, 1));
         rbyte = 1'($urandom_range(0, 1));
         rhalf = 1'($urandom_range(0, 1));
         rsign = 1'($urandom_range(0, 1));
         raddr = 32'h100 + 32'($urandom_range(0, 31));
         applyStimulus(rd, rwe, rbyte, rhalf, rsign, raddr, $urandom, "rand");
      end

      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            checkOutput("b2b/ready_resp", ready_o[1], 32'd1);
            checkOutput("b2b/data", rdata_o[1], b2b_exp[i-1]);
         end
         b2b_exp[i] = predict(1, B2B_WE[i], B2B_BYTE[i], B2B_HALF[i], B2B_SIGN[i],
                              B2B_ADDR[i], B2B_DATA[i]);
         drive(1, B2B_WE[i], B2B_BYTE[i], B2B_HALF[i], B2B_SIGN[i], B2B_ADDR[i], B2B_DATA[i]);
         req_valid_s[1] = 1'b1;
         @(negedge clock);
         checkOutput("b2b/ready_wait", ready_o[1], 32'd0);
         checkOutput("b2b/busy_wait", busy_o[1], 32'd1);
         req_valid_s[1] = i[0];
         drive(1, 1'b1, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
         @(negedge clock);
      end
      checkOutput("b2b/ready_last", ready_o[1], 32'd1);
      checkOutput("b2b/data_last", rdata_o[1], b2b_exp[2]);
      req_valid_s[1] = 1'b0;
      @(negedge clock);
      checkOutput("b2b/ready_idle", ready_o[1], 32'd0);
      checkOutput("b2b/busy_idle", busy_o[1], 32'd0);

      applyStimulus(2, 1, 0, 0, 0, 32'h40, 32'hCAFE_F00D, "rst_init");
      applyStimulus(2, 0, 0, 0, 0, 32'h40, 32'h0,         "rst_preload");
      @(negedge clock);
      drive(2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h1234_5678);
      req_valid_s[2] = 1'b1;
      @(posedge clock);
      @(negedge clock);
      req_valid_s[2] = 1'b0;
      checkOutput("rst_mid/busy_before", busy_o[2], 32'd1);
      @(posedge clock);
      #1;
      rst_n_s[2] = 1'b0;
      #1;
      checkOutput("rst_mid/ready", ready_o[2], 32'd0);
      checkOutput("rst_mid/busy", busy_o[2], 32'd0);
      checkOutput("rst_mid/misaligned", mis_o[2], 32'd0);
      checkOutput("rst_mid/data", rdata_o[2], 32'd0);
      @(negedge clock);
      @(negedge clock);
      rst_n_s[2] = 1'b1;
      applyStimulus(2, 0, 0, 0, 0, 32'h40, 32'h0, "rst_old_contents");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
